morse_timing_decoder: RTL and testbench

Decodes a raw Morse key line into ASCII characters by timing each mark and gap in clock cycles. It is the successor of the pre-classified dot/dash decoder. Symbol timing, symbol depth and glitch rejection are parametrised. It adds digits, word-space emission and error reporting, and it sits between the key input pin and the character output bus.

---
 rtl/morse_timing_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_morse_timing_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/morse_timing_decoder.sv
// Morse key timing decoder.
// Times each key mark and gap in clock cycles and classifies marks as dots or
// dashes. It assembles symbols into a character and emits ASCII for A-Z and 0-9,
// '?' for unknown or overlong patterns, and a space after a word-length gap.
module morse_timing_decoder #(
    parameter int UNIT_CYCLES   = 1000,
    parameter int GLITCH_CYCLES = 2,
    parameter int MAX_SYM       = 5,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       key_in,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       err,
    output logic       busy
);

    localparam int SC_W = $clog2(MAX_SYM + 1);

    localparam logic [CNT_W-1:0] GLITCH_LIM = CNT_W'(GLITCH_CYCLES);
    localparam logic [CNT_W-1:0] CHAR_GAP   = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_GAP   = CNT_W'(5 * UNIT_CYCLES);
    localparam logic [SC_W-1:0]  SYM_FULL   = SC_W'(MAX_SYM);
    localparam logic [SC_W-1:0]  SYM_DECODE = SC_W'(5);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MARK = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_LGAP = 2'd3;

    logic               key_meta_reg, key_s_reg, key_d_prev_reg;
    logic               key_d, key_rise, key_fall;
    logic [1:0]         state_reg, state_next;
    logic [1:0]         saved_state_reg, saved_state_next;
    logic [CNT_W-1:0]   dur_reg, dur_next;
    logic [CNT_W-1:0]   saved_dur_reg, saved_dur_next;
    logic [CNT_W-1:0]   dur_inc, restore_dur;
    logic [CNT_W:0]     restore_sum;
    logic [MAX_SYM-1:0] sym_bits_reg, sym_bits_next;
    logic [SC_W-1:0]    sym_cnt_reg, sym_cnt_next;
    logic               overflow_reg, overflow_next;
    logic [7:0]         char_out_reg, char_out_next;
    logic               char_valid_reg, char_valid_next;
    logic               err_reg, err_next;
    logic [7:0]         decoded;

    // Pattern lookup: length in the top 3 bits, first symbol as MSB of the pattern.
    function automatic logic [7:0] lookup(input logic [2:0] len, input logic [4:0] pat);
        logic [7:0] c;
        c = 8'h3F;
        case ({len, pat})
            {3'd2, 5'b00001}: c = 8'h41; // A .-
            {3'd4, 5'b01000}: c = 8'h42; // B -...
            {3'd4, 5'b01010}: c = 8'h43; // C -.-.
            {3'd3, 5'b00100}: c = 8'h44; // D -..
            {3'd1, 5'b00000}: c = 8'h45; // E .
            {3'd4, 5'b00010}: c = 8'h46; // F ..-.
            {3'd3, 5'b00110}: c = 8'h47; // G --.
            {3'd4, 5'b00000}: c = 8'h48; // H ....
            {3'd2, 5'b00000}: c = 8'h49; // I ..
            {3'd4, 5'b00111}: c = 8'h4A; // J .---
            {3'd3, 5'b00101}: c = 8'h4B; // K -.-
            {3'd4, 5'b00100}: c = 8'h4C; // L .-..
            {3'd2, 5'b00011}: c = 8'h4D; // M --
            {3'd2, 5'b00010}: c = 8'h4E; // N -.
            {3'd3, 5'b00111}: c = 8'h4F; // O ---
            {3'd4, 5'b00110}: c = 8'h50; // P .--.
            {3'd4, 5'b01101}: c = 8'h51; // Q --.-
            {3'd3, 5'b00010}: c = 8'h52; // R .-.
            {3'd3, 5'b00000}: c = 8'h53; // S ...
            {3'd1, 5'b00001}: c = 8'h54; // T -
            {3'd3, 5'b00001}: c = 8'h55; // U ..-
            {3'd4, 5'b00001}: c = 8'h56; // V ...-
            {3'd3, 5'b00011}: c = 8'h57; // W .--
            {3'd4, 5'b01001}: c = 8'h58; // X -..-
            {3'd4, 5'b01011}: c = 8'h59; // Y -.--
            {3'd4, 5'b01100}: c = 8'h5A; // Z --..
            {3'd5, 5'b11111}: c = 8'h30; // 0
            {3'd5, 5'b01111}: c = 8'h31; // 1
            {3'd5, 5'b00111}: c = 8'h32; // 2
            {3'd5, 5'b00011}: c = 8'h33; // 3
            {3'd5, 5'b00001}: c = 8'h34; // 4
            {3'd5, 5'b00000}: c = 8'h35; // 5
            {3'd5, 5'b10000}: c = 8'h36; // 6
            {3'd5, 5'b11000}: c = 8'h37; // 7
            {3'd5, 5'b11100}: c = 8'h38; // 8
            {3'd5, 5'b11110}: c = 8'h39; // 9
            default:          c = 8'h3F;
        endcase
        return c;
    endfunction

    assign key_d    = key_s_reg & ena;
    assign key_rise = key_d & ~key_d_prev_reg;
    assign key_fall = ~key_d & key_d_prev_reg;

    assign dur_inc     = (dur_reg >= WORD_GAP) ? WORD_GAP : dur_reg + CNT_W'(1);
    // A discarded glitch resumes the gap as if the key had never gone down.
    assign restore_sum = {1'b0, saved_dur_reg} + {1'b0, dur_reg} + (CNT_W+1)'(1);
    assign restore_dur = (restore_sum >= {1'b0, WORD_GAP}) ? WORD_GAP : restore_sum[CNT_W-1:0];

    assign decoded = (overflow_reg || sym_cnt_reg > SYM_DECODE)
                   ? 8'h3F : lookup(3'(sym_cnt_reg), sym_bits_reg[4:0]);

    assign char_out   = char_out_reg;
    assign char_valid = char_valid_reg;
    assign err        = err_reg;
    assign busy       = (state_reg == S_MARK) || (state_reg == S_GAP);

    // Two-flop synchronizer plus the previous gated key level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_reg   <= 1'b0;
            key_s_reg      <= 1'b0;
            key_d_prev_reg <= 1'b0;
        end else begin
            key_meta_reg   <= key_in;
            key_s_reg      <= key_meta_reg;
            key_d_prev_reg <= key_d;
        end
    end

    // Next-state logic: mark classification, gap timing and character emission.
    always_comb begin
        state_next       = state_reg;
        saved_state_next = saved_state_reg;
        dur_next         = dur_reg;
        saved_dur_next   = saved_dur_reg;
        sym_bits_next    = sym_bits_reg;
        sym_cnt_next     = sym_cnt_reg;
        overflow_next    = overflow_reg;
        char_out_next    = char_out_reg;
        char_valid_next  = 1'b0;
        err_next         = 1'b0;

        if (key_rise || key_fall) begin
            dur_next = CNT_W'(1);
        end else if (ena) begin
            dur_next = dur_inc;
        end

        if (state_reg == S_MARK) begin
            if (key_fall) begin
                if (dur_reg < GLITCH_LIM) begin
                    state_next = saved_state_reg;
                    dur_next   = restore_dur;
                end else begin
                    if (sym_cnt_reg == SYM_FULL) begin
                        overflow_next = 1'b1;
                    end else begin
                        sym_bits_next = {sym_bits_reg[MAX_SYM-2:0], (dur_reg >= CHAR_GAP)};
                        sym_cnt_next  = sym_cnt_reg + SC_W'(1);
                    end
                    state_next = S_GAP;
                end
            end
        end else if (key_rise) begin
            saved_state_next = state_reg;
            saved_dur_next   = dur_reg;
            state_next       = S_MARK;
        end else if (ena) begin
            if (state_reg == S_GAP && dur_reg >= CHAR_GAP) begin
                char_out_next   = decoded;
                char_valid_next = 1'b1;
                err_next        = (decoded == 8'h3F);
                sym_bits_next   = '0;
                sym_cnt_next    = '0;
                overflow_next   = 1'b0;
                state_next      = S_LGAP;
            end else if (state_reg == S_LGAP && dur_reg >= WORD_GAP) begin
                char_out_next   = 8'h20;
                char_valid_next = 1'b1;
                state_next      = S_IDLE;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            saved_state_reg <= S_IDLE;
            dur_reg         <= '0;
            saved_dur_reg   <= '0;
            sym_bits_reg    <= '0;
            sym_cnt_reg     <= '0;
            overflow_reg    <= 1'b0;
            char_out_reg    <= 8'h00;
            char_valid_reg  <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            saved_state_reg <= saved_state_next;
            dur_reg         <= dur_next;
            saved_dur_reg   <= saved_dur_next;
            sym_bits_reg    <= sym_bits_next;
            sym_cnt_reg     <= sym_cnt_next;
            overflow_reg    <= overflow_next;
            char_out_reg    <= char_out_next;
            char_valid_reg  <= char_valid_next;
            err_reg         <= err_next;
        end
    end

endmodule

// File: tb/tb_morse_timing_decoder.sv
// Testbench for morse_timing_decoder with UNIT_CYCLES=4, GLITCH_CYCLES=2.
// Expected characters are queued as keying is driven and checked when
// char_valid pulses; hand-written sequences check exact pulse timing.
module tb_morse_timing_decoder;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       key_in = 1'b0;
    logic [7:0] char_out;
    logic       char_valid, err, busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] ch;
        logic       err;
    } exp_t;

    typedef struct {
        string      code;
        logic [7:0] ch;
        logic       err;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    morse_timing_decoder #(
        .UNIT_CYCLES(U),
        .GLITCH_CYCLES(2),
        .MAX_SYM(5),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .key_in(key_in),
        .char_out(char_out),
        .char_valid(char_valid),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive the key at level v for n cycles (called on a falling clock edge).
    task automatic hold(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] ch, input logic e);
        exp_t x;
        x.ch  = ch;
        x.err = e;
        sb_q.push_back(x);
    endtask

    // Key a code string: dot = 1 unit, dash = 3 units, 1-unit inter-symbol gaps.
    task automatic send_code(input string code);
        for (int i = 0; i < code.len(); i++) begin
            hold(1'b1, (code[i] == "-") ? 3 * U : U);
            if (i < code.len() - 1) hold(1'b0, U);
        end
        key_in = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"-----",  8'h30, 1'b0};
        vecs[1] = '{".----",  8'h31, 1'b0};
        vecs[2] = '{"......", 8'h3F, 1'b1};
        vecs[3] = '{"..--.",  8'h3F, 1'b1};
        vecs[4] = '{"-.-.",   8'h43, 1'b0};
        vecs[5] = '{"--..",   8'h5A, 1'b0};
        vecs[6] = '{"...--",  8'h33, 1'b0};
        vecs[7] = '{"-..-",   8'h58, 1'b0};
        vecs[8] = '{"----.",  8'h39, 1'b0};
        vecs[9] = '{".-.-",   8'h3F, 1'b1};

        // Output monitor: pops the scoreboard on every char_valid pulse.
        fork
            begin
                logic prev_valid;
                exp_t e;
                prev_valid = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst_n) begin
                        if (err && !char_valid) begin
                            fails++;
                            $display("FAIL err_without_valid: got err=1, expected err=0");
                        end
                        if (char_valid && prev_valid) begin
                            fails++;
                            $display("FAIL pulse_width: got char_valid high 2 cycles, expected 1");
                        end
                        if (char_valid) begin
                            $display("[TB] item char_out=0x%02h err=%0b", char_out, err);
                            if (sb_q.size() == 0) begin
                                tests++;
                                fails++;
                                $display("FAIL unexpected_item: got 0x%02h, expected no output", char_out);
                            end else begin
                                e = sb_q.pop_front();
                                check("char_out", 32'(char_out), 32'(e.ch));
                                check("err", 32'(err), 32'(e.err));
                            end
                        end
                    end
                    prev_valid = char_valid & rst_n;
                end
            end
        join_none

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_char_out", 32'(char_out), 32'h00);
        check("reset_char_valid", 32'(char_valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        hold(1'b0, 30);

        // Case 1/2: ".-" -> 'A' 2 sync + 8 gap + 1 register cycles after release,
        // then a single space 2 + 20 + 1 cycles after release.
        push(8'h41, 1'b0);
        push(8'h20, 1'b0);
        send_code(".-");
        repeat (10) @(negedge clk);
        check("a_early_valid", 32'(char_valid), 32'h0);
        check("a_busy_before", 32'(busy), 32'h1);
        @(negedge clk);
        check("a_valid", 32'(char_valid), 32'h1);
        check("a_char", 32'(char_out), 32'h41);
        check("a_busy_drop", 32'(busy), 32'h0);
        repeat (11) @(negedge clk);
        check("space_early_valid", 32'(char_valid), 32'h0);
        @(negedge clk);
        check("space_valid", 32'(char_valid), 32'h1);
        check("space_char", 32'(char_out), 32'h20);
        hold(1'b0, 100);
        check("space_hold_char", 32'(char_out), 32'h20);

        // Case 5: glitches inside the first and the final gap of "..".
        push(8'h49, 1'b0);
        push(8'h20, 1'b0);
        hold(1'b1, U);
        hold(1'b0, 1);
        hold(1'b1, 1);
        hold(1'b0, 2);
        hold(1'b1, U);
        hold(1'b0, 3);
        hold(1'b1, 1);
        key_in = 1'b0;
        repeat (6) @(negedge clk);
        check("glitch_early_valid", 32'(char_valid), 32'h0);
        @(negedge clk);
        check("glitch_valid_time", 32'(char_valid), 32'h1);
        check("glitch_char", 32'(char_out), 32'h49);
        hold(1'b0, 30);

        // ena low for 10 cycles during the gap freezes the gap timer.
        push(8'h45, 1'b0);
        push(8'h20, 1'b0);
        send_code(".");
        hold(1'b0, 5);
        ena = 1'b0;
        hold(1'b0, 10);
        ena = 1'b1;
        repeat (5) @(negedge clk);
        check("ena_early_valid", 32'(char_valid), 32'h0);
        @(negedge clk);
        check("ena_valid_time", 32'(char_valid), 32'h1);
        hold(1'b0, 30);

        // Table-driven characters (cases 3 and 4 included).
        for (int v = 0; v < 10; v++) begin
            push(vecs[v].ch, vecs[v].err);
            push(8'h20, 1'b0);
            send_code(vecs[v].code);
            hold(1'b0, 30);
        end

        // Case 6: reset mid-dash discards the character.
        hold(1'b1, U);
        hold(1'b0, U);
        hold(1'b1, 6);
        rst_n = 1'b0;
        key_in = 1'b0;
        @(negedge clk);
        check("midreset_char_out", 32'(char_out), 32'h00);
        check("midreset_valid", 32'(char_valid), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        hold(1'b0, 2);
        rst_n = 1'b1;
        hold(1'b0, 10);
        push(8'h45, 1'b0);
        push(8'h20, 1'b0);
        send_code(".");
        hold(1'b0, 30);

        check("queue_empty", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
